trap_controller: RTL

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller_pkg.sv | 35 +++
 rtl/trap_controller.sv | 127 ++++++++++++
 2 files changed

// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap controller: FSM state encoding, trap cause
// codes and the fault priority encoder.
package trap_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FLUSH    = 2'b01,
        ST_REDIRECT = 2'b10
    } trap_state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_PC   = 2'b01;
    localparam logic [1:0] CAUSE_MEM  = 2'b10;
    localparam logic [1:0] CAUSE_SYS  = 2'b11;

    localparam int CNT_W = 4;

    // Illegal PC outranks illegal memory, which outranks a user syscall.
    function automatic logic [1:0] trap_cause(input logic ill_pc,
                                              input logic ill_mem,
                                              input logic user_sys);
        logic [1:0] code;
        if (ill_pc) begin
            code = CAUSE_PC;
        end else if (ill_mem) begin
            code = CAUSE_MEM;
        end else if (user_sys) begin
            code = CAUSE_SYS;
        end else begin
            code = CAUSE_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/trap_controller.sv
// Trap/return sequencer: captures faults and syscalls, flushes the pipeline,
// redirects fetch to the handler (or back to epc) and flips privilege on ack.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int              PC_W         = 16,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = 16'h1000,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Illegal_PC,
    input  logic            Illegal_Memory,
    input  logic            syscall,
    input  logic            eret,
    input  logic [PC_W-1:0] fault_pc,
    input  logic            redirect_ack,
    output logic            Mode,
    output logic            flush,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic [1:0]      cause,
    output logic            busy
);

    trap_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_pending_mode;
    logic             r_flush;
    logic             r_redirect;
    logic             r_busy;
    logic [PC_W-1:0]  r_redirect_pc;
    logic [PC_W-1:0]  r_epc;
    logic [1:0]       r_cause;

    logic             w_user_sys;
    logic             w_event;
    logic [1:0]       w_cause;

    // Trap detection; a syscall from kernel mode is not a trap.
    always_comb begin
        w_user_sys = syscall & ~r_mode;
        w_event    = Illegal_PC | Illegal_Memory | w_user_sys;
        w_cause    = trap_cause(Illegal_PC, Illegal_Memory, w_user_sys);
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= {CNT_W{1'b0}};
            r_mode         <= 1'b1;
            r_pending_mode <= 1'b1;
            r_flush        <= 1'b0;
            r_redirect     <= 1'b0;
            r_busy         <= 1'b0;
            r_redirect_pc  <= TRAP_VECTOR;
            r_epc          <= {PC_W{1'b0}};
            r_cause        <= CAUSE_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        r_state        <= ST_FLUSH;
                        r_cnt          <= CNT_W'(FLUSH_CYCLES - 1);
                        r_epc          <= fault_pc;
                        r_cause        <= w_cause;
                        r_pending_mode <= 1'b1;
                        r_redirect_pc  <= TRAP_VECTOR;
                        r_flush        <= 1'b1;
                        r_busy         <= 1'b1;
                    end else if (eret && r_mode) begin
                        r_state        <= ST_REDIRECT;
                        r_pending_mode <= 1'b0;
                        r_redirect_pc  <= r_epc;
                        r_redirect     <= 1'b1;
                        r_busy         <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_state    <= ST_REDIRECT;
                        r_flush    <= 1'b0;
                        r_redirect <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ack) begin
                        r_state    <= ST_IDLE;
                        r_redirect <= 1'b0;
                        r_busy     <= 1'b0;
                        r_mode     <= r_pending_mode;
                        // A completed return leaves no trap outstanding.
                        if (!r_pending_mode) begin
                            r_cause <= CAUSE_NONE;
                        end else begin
                            r_cause <= r_cause;
                        end
                    end else begin
                        r_state <= ST_REDIRECT;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_flush    <= 1'b0;
                    r_redirect <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign Mode        = r_mode;
    assign flush       = r_flush;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign epc         = r_epc;
    assign cause       = r_cause;
    assign busy        = r_busy;

endmodule
